// File: rtl/sample_pkg.sv
// Shared sample-packing constants and lane ordering helper.
// Used by the packer and the capture path so both agree on lane placement.
package sample_pkg;

  localparam int unsigned SAMPLE_W_DEF = 8;
  localparam int unsigned LANES_DEF    = 8;

  // Physical lane for the cnt-th sample of a word.
  function automatic int unsigned lane_idx(
    input int unsigned cnt,
    input int unsigned lanes,
    input bit          msb_first
  );
    return msb_first ? (lanes - 1 - cnt) : cnt;
  endfunction

endpackage

// File: rtl/pack_out_reg.sv
// Single-entry valid/ready output register for packed words.
// Ports: load_i/data_i/count_i/last_i in, ready_i in, valid_o/data_o/count_o/last_o, load_ok_o out.
module pack_out_reg #(
  parameter int unsigned OUT_W = 64,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [OUT_W-1:0] data_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [OUT_W-1:0] data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             last_o,
  output logic             load_ok_o
);

  logic             valid_q;
  logic [OUT_W-1:0] data_q;
  logic [CNT_W-1:0] count_q;
  logic             last_q;

  // Empty now, or being drained this cycle.
  assign load_ok_o = !valid_q || ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      count_q <= count_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;
  assign last_o  = last_q;

endmodule

// File: rtl/sample_packer.sv
// Packs narrow ADC samples into wide words with valid/ready on both sides.
// Ports: clk_50mhz, rst_n, in_valid/in_sample/in_ready, flush, out_valid/out_ready/out_data/out_count/out_last, busy.
module sample_packer
  import sample_pkg::*;
#(
  parameter int unsigned SAMPLE_W  = SAMPLE_W_DEF,
  parameter int unsigned LANES     = LANES_DEF,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                      clk_50mhz,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [SAMPLE_W-1:0]       in_sample,
  output logic                      in_ready,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SAMPLE_W*LANES-1:0] out_data,
  output logic [$clog2(LANES+1)-1:0] out_count,
  output logic                      out_last,
  output logic                      busy
);

  localparam int unsigned OUT_W = SAMPLE_W * LANES;
  localparam int unsigned CNT_W = $clog2(LANES + 1);

  logic [CNT_W-1:0] lane_cnt_q;
  logic [OUT_W-1:0] acc_q;
  logic             flush_pend_q;

  logic             load_ok;
  logic             accept;
  logic             full_hit;
  logic             flush_ev;
  logic             close;
  logic [OUT_W-1:0] word_d;
  logic [CNT_W-1:0] count_d;
  int unsigned      lane;

  assign full_hit = (lane_cnt_q == CNT_W'(LANES - 1));
  assign in_ready = !(full_hit && !load_ok) && !flush_pend_q;
  assign accept   = in_valid && in_ready;

  // A flush only counts when there is something to emit.
  assign flush_ev = (flush && ((lane_cnt_q != '0) || accept))
                  || flush_pend_q;
  assign close    = (accept && full_hit) || (flush_ev && load_ok);
  assign count_d  = lane_cnt_q + CNT_W'(accept);
  assign lane     = lane_idx(32'(lane_cnt_q), LANES, MSB_FIRST);

  // Accumulator contents including this cycle's sample.
  always_comb begin
    word_d = acc_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (accept && (lane == i)) begin
        word_d[i*SAMPLE_W +: SAMPLE_W] = in_sample;
      end
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      lane_cnt_q   <= '0;
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
    end else if (close) begin
      lane_cnt_q   <= '0;
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      lane_cnt_q <= count_d;
      acc_q      <= word_d;
      if (flush_ev) begin
        flush_pend_q <= 1'b1;
      end
    end
  end

  pack_out_reg #(
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_out (
    .clk       (clk_50mhz),
    .rst_n     (rst_n),
    .load_i    (close),
    .data_i    (word_d),
    .count_i   (count_d),
    .last_i    (flush_ev),
    .ready_i   (out_ready),
    .valid_o   (out_valid),
    .data_o    (out_data),
    .count_o   (out_count),
    .last_o    (out_last),
    .load_ok_o (load_ok)
  );

  assign busy = (lane_cnt_q != '0) || flush_pend_q;

endmodule

// File: tb/tb_sample_packer.sv
// Scoreboard bench for sample_packer (LSB-first and MSB-first instances).
// Queue-based reference model predicts words, in_ready, busy and out_valid.
module tb_sample_packer;

  localparam int L = 8;

  typedef struct {
    logic [63:0] d;
    logic [3:0]  c;
    logic        l;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_sample = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_last, busy;
  logic [63:0] out_data;
  logic [3:0]  out_count;
  logic        in_ready_m, out_valid_m, out_last_m, busy_m;
  logic [63:0] out_data_m;
  logic [3:0]  out_count_m;

  int checks = 0;
  int failures = 0;

  logic [7:0] q[$];
  bit         pend = 1'b0;
  bit         oh = 1'b0;
  word_t       exp0[$];
  logic [63:0] exp1[$];
  word_t       got0[$];
  logic [63:0] got1[$];

  always #10 clk = ~clk;

  sample_packer dut (
    .clk_50mhz (clk),       .rst_n     (rst_n),
    .in_valid  (in_valid),  .in_sample (in_sample),
    .in_ready  (in_ready),  .flush     (flush),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_data  (out_data),  .out_count (out_count),
    .out_last  (out_last),  .busy      (busy)
  );

  sample_packer #(.MSB_FIRST(1'b1)) dut_m (
    .clk_50mhz (clk),         .rst_n     (rst_n),
    .in_valid  (in_valid),    .in_sample (in_sample),
    .in_ready  (in_ready_m),  .flush     (flush),
    .out_valid (out_valid_m), .out_ready (out_ready),
    .out_data  (out_data_m),  .out_count (out_count_m),
    .out_last  (out_last_m),  .busy      (busy_m)
  );

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endfunction

  // Word from the queued samples, first sample at lane 0 or at the top lane.
  function automatic logic [63:0] build(bit msb);
    logic [63:0] w = '0;
    foreach (q[i]) begin
      int pos = msb ? (L - 1 - i) : i;
      w = w | (64'(q[i]) << (8 * pos));
    end
    return w;
  endfunction

  // One cycle of the reference: check visible state, then apply the edge.
  task automatic model();
    bit lok, rdy, acc, fev, cls;
    word_t w;
    lok = !oh || out_ready;
    rdy = !((q.size() == L - 1) && !lok) && !pend;
    chk("out_valid", 64'(out_valid), 64'(oh));
    chk("in_ready", 64'(in_ready), 64'(rdy));
    chk("in_ready_m", 64'(in_ready_m), 64'(rdy));
    chk("busy", 64'(busy), 64'((q.size() != 0) || pend));
    acc = in_valid && rdy;
    if (acc) q.push_back(in_sample);
    fev = (flush && (q.size() != 0)) || pend;
    cls = (q.size() == L) || (fev && lok);
    if (cls) begin
      w.d = build(1'b0);
      w.c = 4'(q.size());
      w.l = fev;
      exp0.push_back(w);
      exp1.push_back(build(1'b1));
      q.delete();
      pend = 1'b0;
    end else if (fev) begin
      pend = 1'b1;
    end
    oh = cls ? 1'b1 : (out_ready ? 1'b0 : oh);
  endtask

  task automatic step(bit v, logic [7:0] s, bit f, bit r);
    @(posedge clk);
    #2;
    in_valid = v;
    in_sample = s;
    flush = f;
    out_ready = r;
    #1;
    model();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst out_data", out_data, 64'd0);
    chk("rst out_count", 64'(out_count), 64'd0);
    chk("rst out_last", 64'(out_last), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst out_data_m", out_data_m, 64'd0);
    q.delete();
    pend = 1'b0;
    oh = 1'b0;
    exp0.delete();
    exp1.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // Monitor: pops expected words whenever a handshake completes.
  logic        stall = 1'b0;
  logic [63:0] held_d = '0;
  logic [3:0]  held_c = '0;
  logic        held_l = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("stall out_valid", 64'(out_valid), 64'd1);
        chk("stall data", out_data, held_d);
        chk("stall count", 64'(out_count), 64'(held_c));
        chk("stall last", 64'(out_last), 64'(held_l));
      end
      stall = out_valid && !out_ready;
      held_d = out_data;
      held_c = out_count;
      held_l = out_last;
      if (out_valid && out_ready) begin
        word_t e, g;
        g.d = out_data;
        g.c = out_count;
        g.l = out_last;
        got0.push_back(g);
        if (exp0.size() == 0) begin
          chk("unexpected word", out_data, 64'd0);
          if (out_data === 64'd0) begin
            failures++;
            $display("FAIL unexpected word actual=%h expected=none", out_data);
          end
        end else begin
          e = exp0.pop_front();
          chk("word data", g.d, e.d);
          chk("word count", 64'(g.c), 64'(e.c));
          chk("word last", 64'(g.l), 64'(e.l));
        end
      end
      if (out_valid_m && out_ready) begin
        got1.push_back(out_data_m);
        if (exp1.size() == 0) begin
          failures++;
          checks++;
          $display("FAIL unexpected msb word actual=%h expected=none", out_data_m);
        end else begin
          chk("msb word data", out_data_m, exp1.pop_front());
        end
      end
    end
  end

  initial begin
    int base;
    out_ready = 1'b1;
    do_reset();

    // Back-to-back full words.
    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("p1 words", 64'(got0.size()), 64'd2);
    if (got0.size() >= 2) begin
      chk("p1 w0", got0[0].d, 64'h0807060504030201);
      chk("p1 w0 cnt", 64'(got0[0].c), 64'd8);
      chk("p1 w0 last", 64'(got0[0].l), 64'd0);
      chk("p1 w1", got0[1].d, 64'h100F0E0D0C0B0A09);
    end
    if (got1.size() >= 1) chk("p1 msb w0", got1[0], 64'h0102030405060708);

    // Partial word via flush, then a lone flush emits nothing.
    base = got0.size();
    step(1'b1, 8'hA1, 1'b0, 1'b1);
    step(1'b1, 8'hA2, 1'b0, 1'b1);
    step(1'b1, 8'hA3, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("p2 words", 64'(got0.size()), 64'(base + 1));
    if (got0.size() == base + 1) begin
      chk("p2 data", got0[base].d, 64'h0000000000A3A2A1);
      chk("p2 cnt", 64'(got0[base].c), 64'd3);
      chk("p2 last", 64'(got0[base].l), 64'd1);
    end
    step(1'b0, 8'h00, 1'b1, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("p2 no empty word", 64'(got0.size()), 64'(base + 1));

    // Backpressure: seven accepted, eighth waits for out_ready.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    chk("p3 eighth blocked", 64'(in_ready), 64'd0);
    step(1'b1, 8'h37, 1'b0, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);

    // Flush while stalled with two samples held.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b1);
    step(1'b1, 8'h51, 1'b0, 1'b0);
    step(1'b1, 8'h52, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h53, 1'b0, 1'b0);
    chk("p4 in_ready", 64'(in_ready), 64'd0);
    chk("p4 busy", 64'(busy), 64'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b0, 1'b1);
    if (got0.size() > 0) begin
      chk("p4 data", got0[$].d, 64'h0000000000005251);
      chk("p4 cnt", 64'(got0[$].c), 64'd2);
      chk("p4 last", 64'(got0[$].l), 64'd1);
    end

    // Reset mid-word, then a clean word.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b1);
    base = got0.size();
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b1);
    repeat (2) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("p5 words", 64'(got0.size()), 64'(base + 1));
    if (got0.size() == base + 1) begin
      chk("p5 data", got0[base].d, 64'h7776757473727170);
    end

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 16) == 0,
           ($urandom % 3) != 0);
    end
    repeat (6) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("drained", 64'(exp0.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample_packer.md
Name: sample_packer

Overview:
- Packs a stream of narrow ADC samples into wide bus words for downstream capture logic.
- Parametrised successor to the fixed 8x8-bit packer: configurable sample width, lanes per word and lane order.
- Adds valid/ready handshakes on both sides, backpressure, and a flush that emits partial words with a lane count.
- Sits between the ADC sample interface and the wide-bus capture/DMA path, in the 50 MHz domain.

Parameters:
- SAMPLE_W, 8, bits per sample.
- LANES, 8, samples per output word (>=2).
- MSB_FIRST, 0, lane order. 0: first sample in bits [SAMPLE_W-1:0]. 1: first sample in the top lane.
- OUT_W, SAMPLE_W*LANES, output word width (derived; not overridden).
- CNT_W, $clog2(LANES+1), width of the lane count (derived).

Ports:
- clk_50mhz  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_sample is valid.
- in_sample  in  SAMPLE_W  sample from the ADC.
- in_ready  out  1  sample is accepted this cycle when in_valid && in_ready.
- flush  in  1  single-cycle request to emit the current partial word.
- out_valid  out  1  out_data/out_count/out_last are valid.
- out_ready  in  1  downstream accepts the word when out_valid && out_ready.
- out_data  out  OUT_W  packed word.
- out_count  out  CNT_W  number of valid lanes (LANES for a full word).
- out_last  out  1  word was closed by a flush.
- busy  out  1  accumulator holds at least one sample, or a flush is pending.

Behaviour:
- Reset (async assert, sync release) clears: out_valid=0, out_data=0, out_count=0, out_last=0, busy=0, lane_cnt=0, accumulator=0, flush_pend=0.
- Reset mid-word discards the partial data; no word is emitted.
- Structure: accumulator (LANES lanes plus lane_cnt 0..LANES-1) feeding one output register.
- Output register is loaded when it is empty or drained the same cycle: load_ok = !out_valid || out_ready.
- Accept: when in_valid && in_ready, the sample is written into lane lane_cnt (or LANES-1-lane_cnt if MSB_FIRST) and lane_cnt increments.
- Word close (full): an accept with lane_cnt==LANES-1 moves the completed word, including this sample, to the output register.
  - out_count=LANES, out_last=0.
  - lane_cnt wraps to 0; accumulator lanes are cleared to 0.
- Latency: last sample accepted in cycle N gives out_valid=1 in cycle N+1.
- Throughput: one sample per cycle sustained with out_ready held high, no bubbles.
- in_ready = !(lane_cnt==LANES-1 && !load_ok) && !flush_pend. This is combinational from out_ready; there is no other path.
- Backpressure: out_valid must stay high, and out_data/out_count/out_last must stay stable, until accepted.
- Flush:
  - A flush with lane_cnt==0, no sample accepted that cycle, and no pending flush is ignored; no empty word is ever emitted.
  - Otherwise a flush with load_ok closes the word: unused lanes are 0, out_count=lanes filled, out_last=1, lane_cnt=0.
  - A sample accepted in the same cycle as flush is included first. If that sample fills the word, one word goes out with out_count=LANES and out_last=1.
  - A flush with !load_ok sets flush_pend. While flush_pend is set, in_ready=0; the word closes on the first cycle with load_ok, then flush_pend clears.
  - A flush arriving while flush_pend is already set is absorbed (no second word).
- busy = (lane_cnt!=0) || flush_pend.
- Counter arithmetic: lane_cnt has CNT_W bits; it never reaches LANES and wraps explicitly to 0.

Decomposition:
- Shared package sample_pkg holds the default SAMPLE_W and LANES constants and a lane-index function implementing MSB_FIRST, shared with the capture path.
- One sub-module is natural: pack_out_reg. It is the single-entry valid/ready output register holding data, count and last, and exposes load_ok.

Test Plan:
- Defaults; out_ready=1; stream samples 0x01..0x10 back-to-back -> words 0x0807060504030201 then 0x100F0E0D0C0B0A09, each out_count=8, out_last=0, in_ready always 1.
- MSB_FIRST=1, samples 0x01..0x08 -> out_data 0x0102030405060708.
- Three samples 0xA1,0xA2,0xA3 then flush -> next cycle out_data 0x0000000000A3A2A1, out_count=3, out_last=1. A later flush with no data produces no word.
- out_ready=0 after the first full word; eight more samples offered -> seven accepted, in_ready=0 on the eighth. Raise out_ready -> the first word is accepted in that cycle, the eighth sample is accepted the same cycle, and the second word appears next cycle.
- Flush while output is stalled with two samples held -> in_ready=0 and busy=1. On out_ready, partial word emitted with out_count=2, out_last=1.
- Assert rst_n=0 with five samples held -> all outputs 0 immediately. After release, 8 new samples give one clean full word.
